aes_inv_cipher_ctrl: RTL

- Iterative AES-128 decryption core controller: sequences one inverse round per clock over a 128-bit state register.
- Drives the existing combinational InvShiftRows / InvSubBytes / AddRoundKey / InvMixColumns datapath.
- Fetches round keys by index from a precomputed key-schedule store.
- Valid/ready handshakes on ciphertext input and plaintext output; sits between the decryption top level and the key expansion block.

---
 rtl/aes_inv_cipher_ctrl.sv | 101 ++++++++++
 1 files changed

// File: rtl/aes_inv_cipher_ctrl.sv
// aes_inv_cipher_ctrl: iterative AES-128 decryption controller, one inverse round per clock.
// Datapath: InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns (skipped on round 0).
module aes_inv_cipher_ctrl #(
    parameter int NR       = 10,
    parameter int RK_IDX_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                key_ready,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [127:0]        in_data,
    output logic [RK_IDX_W-1:0] rk_idx,
    input  logic [127:0]        rk_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        out_data,
    output logic                busy
);
    typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

    fsm_t                fsm, fsm_n;
    logic [RK_IDX_W-1:0] round, round_n;
    logic [127:0]        state, state_n, isr, isb, ark, imc;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? p ^ a : p;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Inverse affine map, then multiplicative inverse as x^254 (0 maps to 0).
    function automatic logic [7:0] inv_sbox(input logic [7:0] y);
        logic [7:0] x, p;
        x = {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
        p = x;
        for (int i = 0; i < 6; i++) p = gmul(gmul(p, p), x);
        return gmul(p, p);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] a);
        logic [31:0] o;
        for (int i = 0; i < 4; i++)
            o[31-8*i -: 8] = gmul(a[31-8*i -: 8], 8'h0e)
                           ^ gmul(a[31-8*((i+1)%4) -: 8], 8'h0b)
                           ^ gmul(a[31-8*((i+2)%4) -: 8], 8'h0d)
                           ^ gmul(a[31-8*((i+3)%4) -: 8], 8'h09);
        return o;
    endfunction

    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign isr[127-8*(4*c+r) -: 8] = state[127-8*(4*((c-r+4)%4)+r) -: 8];
            assign isb[127-8*(4*c+r) -: 8] = inv_sbox(isr[127-8*(4*c+r) -: 8]);
        end
        assign imc[127-32*c -: 32] = inv_mix_col(ark[127-32*c -: 32]);
    end

    assign ark       = isb ^ rk_data;
    assign in_ready  = fsm == IDLE && key_ready;
    assign out_valid = fsm == DONE;
    assign busy      = fsm != IDLE;
    assign rk_idx    = fsm == ROUND ? round : RK_IDX_W'(NR);
    assign out_data  = out_valid ? state : '0;

    always_comb begin
        fsm_n   = fsm;
        round_n = round;
        state_n = state;
        case (fsm)
            IDLE: if (in_valid && in_ready) begin
                fsm_n   = ROUND;
                round_n = RK_IDX_W'(NR - 1);
                state_n = in_data ^ rk_data;
            end
            ROUND: begin
                state_n = round != 0 ? imc : ark;
                round_n = round != 0 ? round - 1'b1 : '0;
                fsm_n   = round != 0 ? ROUND : DONE;
            end
            DONE: fsm_n = out_ready ? IDLE : DONE;
            default: fsm_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm   <= IDLE;
            round <= '0;
            state <= '0;
        end else begin
            fsm   <= fsm_n;
            round <= round_n;
            state <= state_n;
        end
    end
endmodule
